shader_load_scheduler: RTL and testbench

//  Sits between spi_receiver and shader_memory. Collects a complete shader program
//  (NUM_INSTR bytes) from the SPI byte stream into a private buffer. Commits it to

---
 rtl/shader_load_scheduler_pkg.sv | 20 ++
 rtl/shader_load_scheduler_if.sv | 11 +
 rtl/shader_load_scheduler_prog_buffer.sv | 44 ++++
 rtl/shader_load_scheduler.sv | 122 ++++++++++++
 tb/tb_shader_load_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/shader_load_scheduler_pkg.sv
// rtl/shader_load_scheduler_pkg.sv - shared parameters and state type for the shader load scheduler
package shader_load_scheduler_pkg;

    localparam int NUM_INSTR = 10;
    localparam int INSTR_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PENDING,
        COMMIT,
        DONE
    } sched_state_t;

    // Keeps pointers at least one bit wide for single-entry programs.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shader_load_scheduler_if.sv
// rtl/shader_load_scheduler_if.sv - instruction byte stream from the SPI receiver
interface shader_load_scheduler_if #(
    parameter int INSTR_W = 8
);
    logic [INSTR_W-1:0] byte_data;
    logic               byte_valid;
    logic               abort;

    modport master (output byte_data, byte_valid, abort);
    modport slave  (input  byte_data, byte_valid, abort);
endinterface

// File: rtl/shader_load_scheduler_prog_buffer.sv
// rtl/shader_load_scheduler_prog_buffer.sv - private program buffer with wrapping write/read pointers
module shader_load_scheduler_prog_buffer
    import shader_load_scheduler_pkg::*;
#(
    parameter int NUM_INSTR = 10,
    parameter int INSTR_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               wr_en_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic [INSTR_W-1:0] rd_data_o
);
    localparam int PTR_W = ptr_width(NUM_INSTR);

    logic [INSTR_W-1:0] mem [NUM_INSTR];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_INSTR - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is not cleared; resetting the pointers is enough to discard a program.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en_i) begin
                mem[wr_ptr] <= wr_data_i;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (rd_en_i) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
        end
    end

    assign rd_data_o = mem[rd_ptr];

endmodule

// File: rtl/shader_load_scheduler.sv
// rtl/shader_load_scheduler.sv - buffers a shader program and commits it at the vblank rising edge
module shader_load_scheduler
    import shader_load_scheduler_pkg::*;
#(
    parameter int NUM_INSTR = shader_load_scheduler_pkg::NUM_INSTR,
    parameter int INSTR_W   = shader_load_scheduler_pkg::INSTR_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    shader_load_scheduler_if.slave  spi,
    input  logic                    vblank_i,
    input  logic                    clear_ovf_i,
    output logic [INSTR_W-1:0]      mem_instr_o,
    output logic                    mem_load_o,
    output logic                    mem_shift_o,
    output logic                    busy_o,
    output logic                    pending_o,
    output logic                    commit_done_o,
    output logic                    overflow_o
);
    localparam int CNT_W = $clog2(NUM_INSTR + 1);

    sched_state_t       state;
    logic [CNT_W-1:0]   count;
    logic               vblank_q;
    logic [INSTR_W-1:0] rd_data;

    logic vblank_edge, abort_ok, wr_en, rd_en, buf_clear, ovf_set;

    assign vblank_edge = vblank_i && !vblank_q;
    // Once a commit has started it always runs to completion, so abort is only honoured before it.
    assign abort_ok    = spi.abort && (state == IDLE || state == COLLECT || state == PENDING);
    assign wr_en       = spi.byte_valid && !spi.abort && (state == IDLE || state == COLLECT);
    assign rd_en       = (state == PENDING && !spi.abort && vblank_edge)
                      || (state == COMMIT && count != '0);
    assign buf_clear   = abort_ok || state == DONE;
    assign ovf_set     = spi.byte_valid && !abort_ok
                      && (state == PENDING || state == COMMIT || state == DONE);

    shader_load_scheduler_prog_buffer #(
        .NUM_INSTR (NUM_INSTR),
        .INSTR_W   (INSTR_W)
    ) u_prog_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (buf_clear),
        .wr_en_i   (wr_en),
        .wr_data_i (spi.byte_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data)
    );

    // During COMMIT, count holds the number of instructions still to be emitted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            vblank_q      <= 1'b0;
            mem_instr_o   <= '0;
            mem_load_o    <= 1'b0;
            mem_shift_o   <= 1'b0;
            commit_done_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            vblank_q      <= vblank_i;
            mem_instr_o   <= '0;
            mem_load_o    <= 1'b0;
            mem_shift_o   <= 1'b0;
            commit_done_o <= 1'b0;
            overflow_o    <= ovf_set | (overflow_o & ~clear_ovf_i);

            if (abort_ok) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (spi.byte_valid) begin
                            count <= CNT_W'(1);
                            state <= (NUM_INSTR == 1) ? PENDING : COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (spi.byte_valid) begin
                            count <= count + 1'b1;
                            if (count == CNT_W'(NUM_INSTR - 1)) state <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (vblank_edge) begin
                            state       <= COMMIT;
                            count       <= CNT_W'(NUM_INSTR - 1);
                            mem_load_o  <= 1'b1;
                            mem_shift_o <= 1'b1;
                            mem_instr_o <= rd_data;
                        end
                    end
                    COMMIT: begin
                        if (count != '0) begin
                            count       <= count - 1'b1;
                            mem_load_o  <= 1'b1;
                            mem_shift_o <= 1'b1;
                            mem_instr_o <= rd_data;
                        end else begin
                            state         <= DONE;
                            commit_done_o <= 1'b1;
                        end
                    end
                    DONE: begin
                        count <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o    = (state != IDLE);
    assign pending_o = (state == PENDING);

endmodule

// File: tb/tb_shader_load_scheduler.sv
// tb/tb_shader_load_scheduler.sv - directed vector bench for shader_load_scheduler
module tb_shader_load_scheduler;
    import shader_load_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblank;
    logic       clear_ovf;
    logic [7:0] mem_instr;
    logic       mem_load, mem_shift, busy, pending, commit_done, overflow;

    always #5 clk = ~clk;

    shader_load_scheduler_if #(.INSTR_W(8)) spi_if ();

    shader_load_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi           (spi_if),
        .vblank_i      (vblank),
        .clear_ovf_i   (clear_ovf),
        .mem_instr_o   (mem_instr),
        .mem_load_o    (mem_load),
        .mem_shift_o   (mem_shift),
        .busy_o        (busy),
        .pending_o     (pending),
        .commit_done_o (commit_done),
        .overflow_o    (overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       bv;
        logic [7:0] data;
        logic       ab;
        logic       vb;
        logic       clr;
        logic       e_load;
        logic [7:0] e_instr;
        logic       e_pend;
        logic       e_busy;
        logic       e_done;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic bv, input logic [7:0] data, input logic ab,
                                input logic vb, input logic clr, input logic e_load,
                                input logic [7:0] e_instr, input logic e_pend,
                                input logic e_busy, input logic e_done, input logic e_ovf);
        vec_t v;
        v.bv = bv; v.data = data; v.ab = ab; v.vb = vb; v.clr = clr;
        v.e_load = e_load; v.e_instr = e_instr; v.e_pend = e_pend;
        v.e_busy = e_busy; v.e_done = e_done; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endfunction

    function automatic void add_prog(input logic [7:0] base, input logic ovf);
        for (int i = 0; i < 10; i++)
            add(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, i == 9, 1'b1, 1'b0, ovf);
    endfunction

    function automatic void add_commit(input logic [7:0] base, input logic ovf);
        for (int i = 0; i < 10; i++)
            add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, base + 8'(i), 1'b0, 1'b1, 1'b0, ovf);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, ovf);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ovf);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        spi_if.byte_valid = 1'b0;
        spi_if.byte_data  = 8'h00;
        spi_if.abort      = 1'b0;
        clear_ovf         = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n, input logic vb);
        for (int i = 0; i < n; i++) begin
            spi_if.byte_valid = 1'b1;
            spi_if.byte_data  = base + 8'(i);
            vblank            = vb;
            step();
        end
        spi_if.byte_valid = 1'b0;
    endtask

    task automatic expect_commit(input logic [7:0] base, input string tag);
        vblank = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s load[%0d]", tag, k), mem_load, 1'b1);
            check($sformatf("%s shift[%0d]", tag, k), mem_shift, 1'b1);
            check($sformatf("%s instr[%0d]", tag, k), mem_instr, base + 8'(k));
            step();
        end
        check({tag, " done"}, commit_done, 1'b1);
        check({tag, " load_after"}, mem_load, 1'b0);
        vblank = 1'b0;
        step();
        check({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        vblank = 1'b0;
        idle_inputs();

        // Case 1: plain load and commit
        add_prog(8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add_commit(8'h00, 1'b0);
        // Case 2: partial program aborted (abort wins over a simultaneous byte)
        for (int i = 0; i < 4; i++)
            add(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_prog(8'hA0, 1'b0);
        add_commit(8'hA0, 1'b0);
        // Case 3: overflow while pending, clear racing a new overflow, then clear
        add_prog(8'hB0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add_commit(8'hB0, 1'b0);

        step();
        step();
        rst = 1'b0;
        check("reset load", mem_load, 1'b0);
        check("reset shift", mem_shift, 1'b0);
        check("reset instr", mem_instr, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset pending", pending, 1'b0);
        check("reset done", commit_done, 1'b0);
        check("reset ovf", overflow, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            spi_if.byte_valid = vecs[i].bv;
            spi_if.byte_data  = vecs[i].data;
            spi_if.abort      = vecs[i].ab;
            vblank            = vecs[i].vb;
            clear_ovf         = vecs[i].clr;
            step();
            check($sformatf("vec%0d load", i), mem_load, vecs[i].e_load);
            check($sformatf("vec%0d shift", i), mem_shift, vecs[i].e_load);
            check($sformatf("vec%0d instr", i), mem_instr, vecs[i].e_instr);
            check($sformatf("vec%0d pending", i), pending, vecs[i].e_pend);
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d done", i), commit_done, vecs[i].e_done);
            check($sformatf("vec%0d ovf", i), overflow, vecs[i].e_ovf);
        end
        idle_inputs();
        vblank = 1'b0;
        step();

        // Case 4: last byte coincides with a vblank edge
        send_bytes(8'h30, 9, 1'b0);
        send_bytes(8'h39, 1, 1'b1);
        check("c4 pending", pending, 1'b1);
        check("c4 no_load", mem_load, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("c4 hold_load%0d", i), mem_load, 1'b0);
        end
        vblank = 1'b0;
        step();
        check("c4 still_pending", pending, 1'b1);
        expect_commit(8'h30, "c4");

        // Case 5: reset in the fifth commit cycle discards everything
        send_bytes(8'hC0, 10, 1'b0);
        vblank = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check("c5 fifth_load", mem_load, 1'b1);
        check("c5 fifth_instr", mem_instr, 8'hC4);
        rst = 1'b1;
        step();
        check("c5 rst_load", mem_load, 1'b0);
        check("c5 rst_shift", mem_shift, 1'b0);
        check("c5 rst_busy", busy, 1'b0);
        check("c5 rst_instr", mem_instr, 8'h00);
        rst    = 1'b0;
        vblank = 1'b0;
        step();
        check("c5 after_busy", busy, 1'b0);
        check("c5 after_done", commit_done, 1'b0);
        send_bytes(8'hD0, 10, 1'b0);
        check("c5 new_pending", pending, 1'b1);
        expect_commit(8'hD0, "c5");

        // Case 6: vblank held high across collection needs a fresh rising edge
        vblank = 1'b1;
        step();
        send_bytes(8'hE0, 10, 1'b1);
        check("c6 pending", pending, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("c6 hold_load%0d", i), mem_load, 1'b0);
        end
        vblank = 1'b0;
        step();
        check("c6 still_pending", pending, 1'b1);
        expect_commit(8'hE0, "c6");
        check("final ovf", overflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
